rx_frame_fifo: RTL
==================

Name: rx_frame_fifo

Overview:
- Single-clock receive-side frame FIFO; counterpart to the transmit FIFO path.
- Accepts beats from the receive deframer and commits a frame to the reader only when its last beat arrives error-free.
- Errored or overflowed frames are discarded atomically by rewinding the write pointer.
- Read side is first-word-fall-through valid/ready toward the mux consumer.

Parameters:
- DATA_WIDTH, 8, payload bits per beat.
- PTR_WIDTH, 11, log2 of storage depth; DEPTH = 2**PTR_WIDTH beats.
- AFULL_MARGIN, 16, o_afull asserts when free space <= AFULL_MARGIN.
- AEMPTY_MARGIN, 4, o_aempty asserts when committed occupancy <= AEMPTY_MARGIN.

Ports:
- i_clk  in  1  sole clock.
- i_rst  in  1  reset; synchronous to i_clk, active-high.
- i_push  in  1  write beat strobe.
- i_wdata  in  DATA_WIDTH  write beat.
- i_wlast  in  1  beat is last of frame; qualified by i_push.
- i_werr  in  1  frame error flag; qualified by i_push, sticky for the current frame.
- o_rvalid  out  1  o_rdata/o_rlast valid.
- o_rdata  out  DATA_WIDTH  read beat.
- o_rlast  out  1  read beat is last of frame.
- i_pop  in  1  reader ready; a transfer occurs when o_rvalid && i_pop.
- o_frame_cnt  out  PTR_WIDTH+1  committed frames not yet fully read.
- o_drop  out  1  one-cycle pulse when a frame is discarded.
- o_afull  out  1  almost full.
- o_aempty  out  1  almost empty.

Behaviour:
- Storage: DEPTH x (DATA_WIDTH+1) RAM holding {last, data}, with a registered read port.
- Pointers are PTR_WIDTH+1 bits each, carrying a wrap bit:
  - wptr: speculative write pointer.
  - cptr: committed write pointer.
  - rptr: RAM read pointer.
- Full when wptr - rptr == DEPTH.
- Reset: all pointers, o_frame_cnt, the sticky error and overflow flags, and the output register clear. Outputs after reset: o_rvalid=0, o_rdata=0, o_rlast=0, o_drop=0, o_frame_cnt=0, o_afull=0, o_aempty=1. A partial frame in flight at reset is lost.
- Write, not full: RAM[wptr] <= {i_wlast, i_wdata} and wptr increments.
- Write while full: the beat is not stored and the frame's overflow flag is set. Later beats of that frame are also not stored.
- Frame resolution on an i_push with i_wlast:
  - Error flag, overflow flag and current i_werr all clear: cptr <= wptr+1, frame committed, o_frame_cnt increments.
  - Any of them set: wptr <= cptr, o_drop pulses the next cycle, and the flags clear.
- Single-beat frames (i_wlast on the first beat) are legal.
- Reader visibility: only beats in [rptr, cptr) are readable; speculative beats are never read.
- Latency: the first beat of a frame committed at clock edge N is presented with o_rvalid=1 after edge N+2 when the FIFO was previously empty.
- Read stage:
  - A 2-entry prefetch/skid stage behind the RAM read port sustains one beat per cycle with i_pop held high.
  - o_rdata/o_rlast hold steady while o_rvalid && !i_pop.
- Pop of a beat with o_rlast decrements o_frame_cnt.
- Simultaneous commit and last-beat pop in one cycle leave o_frame_cnt unchanged.
- i_pop with o_rvalid=0 is ignored.
- o_afull = (DEPTH - (wptr - rptr)) <= AFULL_MARGIN. It counts speculative beats, so the writer sees pressure during long frames.
- o_aempty = (cptr - rptr) <= AEMPTY_MARGIN. All status flags are registered from post-update pointers, one cycle after the causing edge.
- Wrap-around: pointer subtraction is modulo 2**(PTR_WIDTH+1). Frames may straddle the RAM end without special handling.
- A frame larger than DEPTH always overflows and is dropped. The FIFO remains consistent afterwards.

Test Plan:
- Reset, then push a 4-beat frame 0x11..0x14 with last on 0x14 and i_pop=1. Required: o_frame_cnt 0->1; o_rvalid high exactly 2 cycles after the commit edge; beats 0x11,0x12,0x13,0x14 on consecutive cycles with o_rlast only on 0x14; o_frame_cnt returns to 0.
- Push a 3-beat frame with i_werr=1 on beat 2, then a 2-beat good frame 0xA0,0xA1. Required: o_drop pulses once; reader sees only 0xA0,0xA1; o_frame_cnt peaks at 1.
- PTR_WIDTH=4, i_pop=0, push a 20-beat frame. Required: o_afull asserts; o_drop pulses at the last beat; wptr==cptr==0. Then push a 1-beat frame 0x5A: it reads back correctly.
- Pre-advance pointers to DEPTH-2, then push a 5-beat frame. Required: correct wrap readback and o_frame_cnt=1.
- Reader toggles i_pop randomly over 100 random-length frames. Required: data order preserved, no beat duplicated or lost, o_rdata stable while stalled.
- Assert i_rst mid-frame and mid-read. Required: all outputs at reset values the next cycle; a following frame reads back cleanly.

Source files
------------

// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo: receive-side frame FIFO. Beats are written speculatively and
// become visible to the reader only once the whole frame arrives error-free.
// Errored or overflowed frames are discarded by rewinding the write pointer.
// The read side is first-word-fall-through behind a registered RAM read port.
module rx_frame_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int PTR_WIDTH     = 11,
  parameter int AFULL_MARGIN  = 16,
  parameter int AEMPTY_MARGIN = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_wlast,
  input  logic                  i_werr,
  output logic                  o_rvalid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rlast,
  input  logic                  i_pop,
  output logic [PTR_WIDTH:0]    o_frame_cnt,
  output logic                  o_drop,
  output logic                  o_afull,
  output logic                  o_aempty
);

  localparam int DEPTH = 2 ** PTR_WIDTH;
  localparam logic [PTR_WIDTH:0]   DEPTH_P  = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH+1:0] AFULL_M  = (PTR_WIDTH+2)'(AFULL_MARGIN);
  localparam logic [PTR_WIDTH+1:0] AEMPTY_M = (PTR_WIDTH+2)'(AEMPTY_MARGIN);

  // Each RAM word is {last, data}.
  logic [DATA_WIDTH:0] mem [DEPTH];

  logic [PTR_WIDTH:0]  wptr_reg, wptr_next;
  logic [PTR_WIDTH:0]  cptr_reg, cptr_next;
  logic [PTR_WIDTH:0]  rptr_reg, rptr_next;
  logic [PTR_WIDTH:0]  fcnt_reg, fcnt_next;
  logic                err_reg, err_next;
  logic                ovf_reg, ovf_next;
  logic                drop_reg, drop_next;
  logic                afull_reg, aempty_reg;
  logic [DATA_WIDTH:0] ram_q_reg;
  logic                ram_vld_reg;
  logic [DATA_WIDTH:0] sk0_reg, sk0_next, sk1_reg, sk1_next;
  logic [1:0]          sk_cnt_reg, sk_cnt_next, sk_cnt_pop;

  logic                full, wr_en, rd_en, pop, pop_last, commit;
  logic [PTR_WIDTH:0]  used_next, occ_next;
  logic [PTR_WIDTH+1:0] free_next;

  assign full     = (wptr_reg - rptr_reg) == DEPTH_P;
  // Once a frame has overflowed, none of its remaining beats are stored.
  assign wr_en    = i_push && !full && !ovf_reg;
  assign o_rvalid = sk_cnt_reg != 2'd0;
  assign pop      = o_rvalid && i_pop;
  assign pop_last = pop && sk0_reg[DATA_WIDTH];

  // Write side: speculative advance, commit on a clean last beat, rewind otherwise.
  always_comb begin
    wptr_next = wptr_reg;
    cptr_next = cptr_reg;
    err_next  = err_reg;
    ovf_next  = ovf_reg;
    drop_next = 1'b0;
    commit    = 1'b0;
    if (i_push) begin
      if (wr_en) wptr_next = wptr_reg + 1'b1;
      else       ovf_next  = 1'b1;
      if (i_werr) err_next = 1'b1;
      if (i_wlast) begin
        if (err_reg || ovf_reg || i_werr || !wr_en) begin
          wptr_next = cptr_reg;
          drop_next = 1'b1;
        end else begin
          cptr_next = wptr_reg + 1'b1;
          commit    = 1'b1;
        end
        err_next = 1'b0;
        ovf_next = 1'b0;
      end
    end
  end

  // Read side: fetch a committed beat only if the skid stage is sure to have room
  // for it when it lands, even if the reader stalls on the next cycle.
  always_comb begin
    sk_cnt_pop = sk_cnt_reg - {1'b0, pop};
    rd_en      = (cptr_reg != rptr_reg) && ((sk_cnt_pop + {1'b0, ram_vld_reg}) <= 2'd1);
    rptr_next  = rptr_reg + {{PTR_WIDTH{1'b0}}, rd_en};
    sk0_next   = pop ? sk1_reg : sk0_reg;
    sk1_next   = sk1_reg;
    if (ram_vld_reg) begin
      if (sk_cnt_pop == 2'd0) sk0_next = ram_q_reg;
      else                    sk1_next = ram_q_reg;
    end
    sk_cnt_next = sk_cnt_pop + {1'b0, ram_vld_reg};
  end

  // Frame counter and status flags computed from post-update pointers.
  always_comb begin
    fcnt_next = fcnt_reg;
    case ({commit, pop_last})
      2'b10:   fcnt_next = fcnt_reg + 1'b1;
      2'b01:   fcnt_next = fcnt_reg - 1'b1;
      default: fcnt_next = fcnt_reg;
    endcase
    used_next = wptr_next - rptr_next;
    occ_next  = cptr_next - rptr_next;
    free_next = {1'b0, DEPTH_P} - {1'b0, used_next};
  end

  // Storage array: write port plus registered read port, no reset so it maps to RAM.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wptr_reg[PTR_WIDTH-1:0]] <= {i_wlast, i_wdata};
    if (rd_en) ram_q_reg <= mem[rptr_reg[PTR_WIDTH-1:0]];
  end

  // Control state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_reg    <= '0;
      cptr_reg    <= '0;
      rptr_reg    <= '0;
      fcnt_reg    <= '0;
      err_reg     <= 1'b0;
      ovf_reg     <= 1'b0;
      drop_reg    <= 1'b0;
      afull_reg   <= 1'b0;
      aempty_reg  <= 1'b1;
      ram_vld_reg <= 1'b0;
      sk0_reg     <= '0;
      sk1_reg     <= '0;
      sk_cnt_reg  <= 2'd0;
    end else begin
      wptr_reg    <= wptr_next;
      cptr_reg    <= cptr_next;
      rptr_reg    <= rptr_next;
      fcnt_reg    <= fcnt_next;
      err_reg     <= err_next;
      ovf_reg     <= ovf_next;
      drop_reg    <= drop_next;
      afull_reg   <= free_next <= AFULL_M;
      aempty_reg  <= {1'b0, occ_next} <= AEMPTY_M;
      ram_vld_reg <= rd_en;
      sk0_reg     <= sk0_next;
      sk1_reg     <= sk1_next;
      sk_cnt_reg  <= sk_cnt_next;
    end
  end

  assign o_rdata     = sk0_reg[DATA_WIDTH-1:0];
  assign o_rlast     = sk0_reg[DATA_WIDTH];
  assign o_frame_cnt = fcnt_reg;
  assign o_drop      = drop_reg;
  assign o_afull     = afull_reg;
  assign o_aempty    = aempty_reg;

endmodule
